serial_deserializer: RTL and testbench

Serial-in / parallel-out receiver, the receiving end of the team's right-shifting parallel-load shifter link. Accepts one bit per qualified clock, LSB first, and assembles WIDTH-bit words. Presents each completed word on a valid/ready output holding register. A flush request right-justifies a partial word, with zero fill or sign extension.

---
 rtl/serial_deserializer.sv | 148 ++++++++++++++
 tb/tb_serial_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Serial-in / parallel-out receiver: the receiving end of the right-shifting,
// parallel-load shifter link. Bits arrive LSB first, one per accepted cycle
// (bit_valid && bit_ready), and are assembled into WIDTH-bit words. Each
// completed word lands in a valid/ready output holding register. A flush
// request right-justifies a partial word by shifting in fill bits. The fill
// bit is either zero or a copy of the most recently received bit.
//
// Parameters
//   WIDTH       word length in bits, 2..15
//
// Ports
//   clk         system clock, all state changes on posedge
//   reset_n     synchronous active-low reset
//   bit_in      serial data bit, LSB of the word first
//   bit_valid   bit_in is valid this cycle
//   bit_ready   a bit can be accepted this cycle (low while flushing)
//   flush       complete the current partial word
//   asr         flush fill mode: 1 = sign-extend, 0 = zero-fill
//   data_out    last completed word
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer takes data_out this cycle
//   overrun     sticky: a completed word was dropped (cleared by reset only)
//   count       bits in the current partial word, 0..WIDTH-1
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    input  logic             asr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic [3:0]       count
);

    typedef enum logic {
        COLLECT = 1'b0,
        FLUSH   = 1'b1
    } state_t;

    localparam logic [3:0] WIDTH_CNT = 4'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             fill;

    // Per-cycle shift decision shared by both states.
    logic             shift_en;
    logic             shift_bit;
    logic [WIDTH-1:0] sr_shifted;
    logic [3:0]       cnt_inc;
    logic             word_done;
    logic             flush_start;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    //       path leaves it unassigned and no latch is inferred.
    always_comb begin
        shift_en  = 1'b0;
        shift_bit = fill;
        unique case (state)
            COLLECT: begin
                shift_en  = bit_valid;
                shift_bit = bit_in;
            end
            FLUSH: begin
                shift_en  = 1'b1;
                shift_bit = fill;
            end
            default: ;
        endcase

        sr_shifted = {shift_bit, sr[WIDTH-1:1]};
        cnt_inc    = count + 4'd1;
        word_done  = shift_en && (cnt_inc == WIDTH_CNT);

        // A flush is honoured only in COLLECT, only when there is something to
        // flush, and never when the same edge already completes the word.
        flush_start = (state == COLLECT) && flush && !word_done &&
                      (shift_en || (count != 4'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= COLLECT;
            sr         <= '0;
            fill       <= 1'b0;
            count      <= 4'd0;
            bit_ready  <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Shift register and bit counter.
            if (shift_en) begin
                sr    <= sr_shifted;
                count <= word_done ? 4'd0 : cnt_inc;
            end

            // Output holding register. A word completing while the previous
            // one is still unconsumed is dropped and flagged.
            if (word_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= sr_shifted;
                    data_valid <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // Control FSM with registered bit_ready.
            unique case (state)
                COLLECT: begin
                    if (flush_start) begin
                        // Fill copies the newest bit: the one arriving this
                        // edge if any, otherwise the top of the register.
                        fill      <= asr & (shift_en ? bit_in : sr[WIDTH-1]);
                        state     <= FLUSH;
                        bit_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (word_done) begin
                        state     <= COLLECT;
                        bit_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    bit_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Self-checking bench for serial_deserializer (WIDTH = 8). A reference model
// keeps the partial word as a queue of received bits and a flush as a
// precomputed word plus a countdown; every cycle all outputs are compared
// against it. Directed scenarios cover the documented cases with literal
// expected words, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic         flush;
    logic         asr;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         overrun;
    logic [3:0]   count;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .flush      (flush),
        .asr        (asr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .count      (count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_bits[$];      // bits of the partial word, oldest first
    int           m_flush_left;   // cycles left until the flushed word completes
    logic [W-1:0] m_flush_word;
    logic [W-1:0] m_dout;
    bit           m_dv;
    bit           m_ov;

    // Right-justified word: received bits at the bottom, fill above them.
    function automatic logic [W-1:0] pack_fill(input bit f);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++)
            w[i] = (i < m_bits.size()) ? m_bits[i][0] : f;
        return w;
    endfunction

    function automatic void start_flush(input bit f);
        m_flush_word = pack_fill(f);
        m_flush_left = W - m_bits.size();
        m_bits.delete();
    endfunction

    // Applies the inputs present at the current posedge.
    task automatic model_step();
        bit           done;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (!reset_n) begin
            m_bits.delete();
            m_flush_left = 0;
            m_dout = '0;
            m_dv = 1'b0;
            m_ov = 1'b0;
            return;
        end
        if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                done = 1'b1;
                word = m_flush_word;
            end
        end else if (bit_valid) begin
            m_bits.push_back(int'(bit_in));
            if (m_bits.size() == W) begin
                done = 1'b1;
                word = pack_fill(1'b0);
                m_bits.delete();
            end else if (flush) begin
                start_flush(asr & bit_in);
            end
        end else if (flush && m_bits.size() > 0) begin
            start_flush(asr & m_bits[m_bits.size()-1][0]);
        end

        if (done) begin
            if (!m_dv || data_ready) begin
                m_dout = word;
                m_dv = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (m_dv && data_ready) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic compare();
        int exp_count;
        exp_count = (m_flush_left > 0) ? (W - m_flush_left) : m_bits.size();
        check("bit_ready",  bit_ready,  m_flush_left == 0);
        check("data_valid", data_valid, m_dv);
        check("data_out",   data_out,   m_dout);
        check("overrun",    overrun,    m_ov);
        check("count",      count,      exp_count);
    endtask

    // One clock: inputs already set, model advances on the edge, outputs
    // sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic drive(input bit v, input bit b, input bit f, input bit a, input bit r);
        bit_valid  = v;
        bit_in     = b;
        flush      = f;
        asr        = a;
        data_ready = r;
        cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit r);
        for (int i = 0; i < W; i++)
            drive(1, w[i], 0, 0, r);
    endtask

    initial begin
        reset_n = 1'b0; bit_in = 0; bit_valid = 0; flush = 0; asr = 0; data_ready = 0;
        do_reset();
        check("rst_dout", data_out, 8'h00);
        check("rst_ready", bit_ready, 1);

        // 1: plain word, LSB first
        send_word(8'hA5, 1);
        check("t1_dout", data_out, 8'hA5);
        check("t1_dv", data_valid, 1);
        drive(0, 0, 0, 0, 1);
        check("t1_dv_drop", data_valid, 0);
        check("t1_count", count, 0);

        // 2: partial word 1,0,1 zero-filled
        drive(1, 1, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            check("t2_busy", bit_ready, 0);
        end
        drive(0, 0, 0, 0, 0);
        check("t2_dout", data_out, 8'h05);
        check("t2_dv", data_valid, 1);
        check("t2_ov", overrun, 0);
        drive(0, 0, 0, 0, 1);

        // 3: partial word 0,1,1 sign-extended, then zero-filled
        for (int m = 1; m >= 0; m--) begin
            drive(1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0); drive(1, 1, 0, 0, 0);
            drive(0, 0, 1, m[0], 0);
            for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
            check("t3_dout", data_out, m ? 8'hFE : 8'h06);
            drive(0, 0, 0, 0, 1);
        end

        // 4: overrun while the consumer stalls
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        check("t4_dout", data_out, 8'h3C);
        check("t4_ov", overrun, 1);
        drive(0, 0, 0, 0, 1);
        check("t4_dv", data_valid, 0);
        check("t4_ov_sticky", overrun, 1);

        // 5: consume on the same edge the next word completes
        do_reset();
        send_word(8'h81, 0);
        for (int i = 0; i < W - 1; i++) drive(1, i[0] ? 1'b1 : (i != 0), 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        check("t5_dout", data_out, 8'h7E);
        check("t5_dv", data_valid, 1);
        check("t5_ov", overrun, 0);
        drive(0, 0, 0, 0, 1);

        // 6: reset in mid-word with bit_valid held high
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
        reset_n = 1'b0;
        drive(1, 1, 0, 0, 0);
        reset_n = 1'b1;
        check("t6_count", count, 0);
        send_word(8'h00, 0);
        check("t6_dout", data_out, 8'h00);
        check("t6_dv", data_valid, 1);
        check("t6_ov", overrun, 0);
        drive(0, 0, 0, 0, 1);

        // 7: idle flush is a no-op; flush on the final bit is ignored
        drive(0, 0, 1, 1, 0);
        check("t7_noop_ready", bit_ready, 1);
        check("t7_noop_count", count, 0);
        for (int i = 0; i < W - 1; i++) drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 0);
        check("t7_dout", data_out, 8'hFF);
        check("t7_ready", bit_ready, 1);
        drive(0, 0, 0, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
